// File: rtl/timer_counter_pkg.sv
// timer_counter_pkg
//   Shared definitions for the memory-mapped timer/counter:
//   FSM state encoding, register word offsets, CTRL bit positions,
//   and MODE codes.
package timer_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_PRESET   = 2'd1;
  localparam logic [1:0] ADDR_COUNT    = 2'd2;
  localparam logic [1:0] ADDR_PRESCALE = 2'd3;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  // Only the exact auto-reload code reloads; 1x codes behave as one-shot.
  function automatic logic is_auto(input logic [1:0] mode);
    return (mode == MODE_AUTO);
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// timer_counter_if
//   Data-bus slice seen by the timer: word offset, write strobe, store
//   data, combinational read data and the interrupt request.
//   master: CPU side (drives addr/we/wdata, samples rdata/irq)
//   slave : timer side
interface timer_counter_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, we, wdata, input rdata, irq);
  modport slave  (input addr, we, wdata, output rdata, irq);
endinterface

// File: rtl/timer_counter_prescaler.sv
// timer_prescaler
//   8-bit tick generator. tick is high one cycle out of every prescale+1.
//   restart reloads the down-counter so the first tick after a restart
//   arrives prescale+1 cycles later.
//   Ports: clk, rst (async, active-low), restart, prescale[7:0], tick.
//   Compiled only when TIMER_PRESCALE_EN is defined.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic [7:0] prescale,
  output logic       tick
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (restart || (cnt == 8'd0)) begin
      cnt <= prescale;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

  assign tick = (cnt == 8'd0);

endmodule
`endif

// File: rtl/timer_counter.sv
// timer_counter
//   Memory-mapped down-counting timer on the CPU data bus. Software loads
//   PRESET and enables via CTRL; the block counts down and flags an
//   interrupt on expiry (one-shot or auto-reload).
//   Ports: clk, rst (async, active-low), bus (timer_counter_if.slave:
//   addr, we, wdata, rdata, irq).
//   Optional: TIMER_PRESCALE_EN adds an 8-bit PRESCALE register at
//   offset 3 that slows COUNT decrements to one per PRESCALE+1 cycles.
//
//   state   | meaning
//   --------+---------------------------------------------
//   IDLE    | stopped, waiting for EN
//   LOAD    | COUNT <= PRESET
//   CNT     | counting down toward expiry
//   INT     | expired; flag irq, reload or stop
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  timer_counter_if.slave bus
);

  state_t           state, state_d;
  logic             ctrl_en, ctrl_en_d;
  logic [1:0]       ctrl_mode;
  logic             ctrl_im, ctrl_im_d;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count, count_d;
  logic             irq_flag, irq_flag_d;
  logic             irq_q, irq_d;
  logic             ctrl_wr, preset_wr;
  logic             tick;
  logic [31:0]      rdata_c;
  logic             unused_wdata;

  assign ctrl_wr   = bus.we && (bus.addr == ADDR_CTRL);
  assign preset_wr = bus.we && (bus.addr == ADDR_PRESET);
  assign unused_wdata = ^bus.wdata;

`ifdef TIMER_PRESCALE_EN
  logic [7:0] prescale;
  logic       prescale_wr;
  logic       load_restart;

  assign prescale_wr  = bus.we && (bus.addr == ADDR_PRESCALE);
  assign load_restart = (state == ST_LOAD);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale <= '0;
    end else if (prescale_wr) begin
      prescale <= bus.wdata[7:0];
    end
  end

  timer_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .restart  (load_restart),
    .prescale (prescale),
    .tick     (tick)
  );
`else
  assign tick = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d    = state;
    count_d    = count;
    ctrl_en_d  = ctrl_wr ? bus.wdata[CTRL_EN] : ctrl_en;
    ctrl_im_d  = ctrl_wr ? bus.wdata[CTRL_IM] : ctrl_im;
    irq_flag_d = irq_flag;

    // IDLE looks at the registered EN so a start write costs one cycle;
    // LOAD/CNT look at the written value so a stop write freezes COUNT
    // on the very edge it lands.
    case (state)
      ST_IDLE: begin
        if (ctrl_en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!ctrl_en_d) begin
          state_d = ST_IDLE;
        end else begin
          count_d = preset;
          state_d = ST_CNT;
        end
      end
      ST_CNT: begin
        if (!ctrl_en_d) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          if (count > CNT_W'(1)) begin
            count_d = count - CNT_W'(1);
          end else begin
            count_d = '0;
            state_d = ST_INT;
          end
        end
      end
      ST_INT: begin
        if (is_auto(ctrl_mode)) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
          // A concurrent CTRL write keeps the EN it wrote.
          if (!ctrl_wr) ctrl_en_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ctrl_wr) begin
      irq_flag_d = 1'b0;
    end else if (state == ST_INT) begin
      irq_flag_d = 1'b1;
    end else if (is_auto(ctrl_mode)) begin
      irq_flag_d = 1'b0;
    end

    irq_d = ctrl_im_d & irq_flag_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= MODE_ONESHOT;
      ctrl_im   <= 1'b0;
      preset    <= '0;
      count     <= '0;
      irq_flag  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      ctrl_en  <= ctrl_en_d;
      ctrl_im  <= ctrl_im_d;
      count    <= count_d;
      irq_flag <= irq_flag_d;
      irq_q    <= irq_d;
      if (ctrl_wr) ctrl_mode <= bus.wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
      if (preset_wr) preset <= bus.wdata[CNT_W-1:0];
    end
  end

  always_comb begin
    rdata_c = '0;
    case (bus.addr)
      ADDR_CTRL: begin
        rdata_c[CTRL_EN]                     = ctrl_en;
        rdata_c[CTRL_MODE_MSB:CTRL_MODE_LSB] = ctrl_mode;
        rdata_c[CTRL_IM]                     = ctrl_im;
      end
      ADDR_PRESET: rdata_c[CNT_W-1:0] = preset;
      ADDR_COUNT:  rdata_c[CNT_W-1:0] = count;
      ADDR_PRESCALE: begin
`ifdef TIMER_PRESCALE_EN
        rdata_c[7:0] = prescale;
`else
        rdata_c = '0;
`endif
      end
      default: rdata_c = '0;
    endcase
  end

  assign bus.rdata = rdata_c;
  assign bus.irq   = irq_q;

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped programmable timer/counter on the CPU data bus, directly downstream of the core's data-memory port.
- Consumes the same store address, store data and write-enable that drive data memory; address decode selects this block instead of dm_1k.
- Counts down from a software-loaded preset and raises an interrupt on expiry.
- rdata is combinational; the core's existing memory-output register samples it like memory_out.

Parameters:
- CNT_W, 32, width of PRESET and COUNT registers (1..32); unused upper read bits return 0.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-low (block resets while rst==0).
- addr  input  2  word offset within block (byte address bits [3:2]).
- we  input  1  write strobe, sampled on rising clk.
- wdata  input  32  store data.
- rdata  output  32  read data, combinational from addr and register state.
- irq  output  1  interrupt request, registered.

Behaviour:
- Register map, by addr:
  - 0 CTRL: bit0 EN, bits[2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), bit3 IM (interrupt mask, 1 = enabled); other bits read 0.
  - 1 PRESET: read/write.
  - 2 COUNT: read-only; writes ignored.
  - 3: reads 0, writes ignored.
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, irq=0, rdata follows the reset register values.
- FSM states IDLE, LOAD, CNT, INT; all transitions on rising clk:
  - IDLE: EN=1 -> LOAD.
  - LOAD: COUNT<=PRESET -> CNT.
  - CNT: if EN=0 -> IDLE, COUNT holds. Else if COUNT>1 -> COUNT-1. Else (COUNT<=1) COUNT<=0 -> INT.
  - INT, MODE 00: EN<=0 -> IDLE.
  - INT, MODE 01: -> LOAD.
- PRESET=0: LOAD -> CNT (COUNT 0) -> INT on the next edge.
- irq_flag is set on the edge leaving INT.
  - MODE 00: sticky until any CTRL write or reset.
  - MODE 01: cleared on the following edge (1-cycle pulse).
- irq = IM & irq_flag.
- Timing:
  - MODE 00: after CTRL write at edge k with EN=1, irq rises after edge k+PRESET+3 (PRESET>=1).
  - MODE 01: irq period is PRESET+2 cycles.
- Write priority:
  - A CTRL write in the same cycle as INT's EN auto-clear wins; the written EN is kept.
  - A CTRL write with EN=0 during LOAD/CNT -> IDLE next edge; COUNT frozen.
  - A CTRL write also clears irq_flag, same edge.
- PRESET write during CNT does not affect the running COUNT; it takes effect at the next LOAD.
- rst asserted mid-count: immediate return to all reset values; no irq glitch.

Optional Feature:
- TIMER_PRESCALE_EN defined:
  - addr 3 is an 8-bit PRESCALE register (r/w, reset 0).
  - In CNT, COUNT decrements only on a tick every PRESCALE+1 cycles.
  - The prescaler restarts on each LOAD.
  - The INT transition also waits for a tick.
- Undefined: addr 3 reads 0 and decrements occur every cycle.

Decomposition:
- Shared defines package:
  - state encodings IDLE/LOAD/CNT/INT;
  - register offsets (CTRL=0, PRESET=1, COUNT=2, PRESCALE=3);
  - CTRL bit indices (EN=0, MODE=2:1, IM=3);
  - mode codes.
- Sub-module timer_prescaler: 8-bit tick generator with restart input; instantiated only under TIMER_PRESCALE_EN.

Test Plan:
- Reset: hold rst=0 with random we/wdata -> rdata=0 at all offsets, irq=0; release -> state IDLE.
- One-shot: PRESET=3, then CTRL=0x9 at edge k -> COUNT reads 3,2,1,0 after edges k+2..k+5; irq=1 after edge k+6 and stays 1; CTRL reads 0x8; CTRL write 0x8 -> irq=0 next cycle.
- Auto-reload: PRESET=2, CTRL=0xB -> irq 1-cycle pulses every 4 cycles for at least 5 periods; EN stays 1.
- Mask and stop: CTRL=0x1 (IM=0), PRESET=1 -> irq stays 0 while COUNT reaches 0. Rerun with PRESET=10, write CTRL=0x8 mid-count at COUNT=6 -> COUNT freezes at 6, no irq.
- Boundaries:
  - PRESET=0, CTRL=0x9 -> irq after edge k+4.
  - Write COUNT=0x55 -> ignored.
  - PRESET rewritten to 7 during a count of 5 -> current run ends at 0; next auto-reload loads 7.
  - rst pulsed mid-CNT -> all registers 0 asynchronously.
- Prescale (macro on): PRESCALE=1, PRESET=2, one-shot -> COUNT decrements every 2 cycles; irq after edge k+7.
